// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: the carry chain is cut into SEG-bit slices, one slice per
// stage, with valid/ready handshakes and cout/zero/parity/overflow flags on the result.
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ip1,
  input  logic [WIDTH-1:0] ip2,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             zero,
  output logic             parity,
  output logic             overflow
);

  localparam int STAGES = WIDTH / SEG;
  // Inter-stage register count; kept at least 1 so the arrays stay legal when STAGES == 1.
  localparam int NI = (STAGES > 1) ? STAGES - 1 : 1;

  if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_param_check
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of SEG");
  end

  function automatic logic [SEG:0] slice_add(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           c);
    return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, c};
  endfunction

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             a_top;
  logic             b_top;
  logic [STAGES-1:0] vld_p;

  logic [WIDTH-1:0] a_p [NI];
  logic [WIDTH-1:0] b_p [NI];
  logic [WIDTH-1:0] s_p [NI];
  logic             c_p [NI];

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             zero_q;
  logic             parity_q;
  logic             ovf_q;

  // A single global enable: the whole pipe freezes while a result waits at the output.
  assign en       = !vld_p[STAGES-1] || out_ready;
  assign in_ready = en && rst_n;
  assign b_eff    = sub ? ~ip2 : ip2;
  assign c0       = sub | cin;

  // Operand sign bits seen by the final stage, for the signed-overflow flag.
  assign a_top = (STAGES == 1) ? ip1[WIDTH-1]   : a_p[NI-1][WIDTH-1];
  assign b_top = (STAGES == 1) ? b_eff[WIDTH-1] : b_p[NI-1][WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else if (en) begin
      vld_p[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG:0]     add;
    logic [WIDTH-1:0] s_nx;

    if (k == 0) begin : g_first
      assign add = slice_add(ip1[SEG-1:0], b_eff[SEG-1:0], c0);
      always_comb begin
        s_nx          = '0;
        s_nx[SEG-1:0] = add[SEG-1:0];
      end
    end else begin : g_next
      assign add = slice_add(a_p[k-1][k*SEG +: SEG], b_p[k-1][k*SEG +: SEG], c_p[k-1]);
      always_comb begin
        s_nx                = s_p[k-1];
        s_nx[k*SEG +: SEG]  = add[SEG-1:0];
      end
    end

    if (k < STAGES - 1) begin : g_reg
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      if (k == 0) begin : g_src0
        assign a_in = ip1;
        assign b_in = b_eff;
      end else begin : g_srck
        assign a_in = a_p[k-1];
        assign b_in = b_p[k-1];
      end

      // Stage k -> k+1 boundary: operands, partial sum and slice carry move together.
      always_ff @(posedge clk) begin
        if (en) begin
          a_p[k] <= a_in;
          b_p[k] <= b_in;
          s_p[k] <= s_nx;
          c_p[k] <= add[SEG];
        end
      end
    end else begin : g_out
      // Final boundary: full sum and its flags become the visible outputs.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q    <= '0;
          cout_q   <= 1'b0;
          zero_q   <= 1'b0;
          parity_q <= 1'b0;
          ovf_q    <= 1'b0;
        end else if (en) begin
          sum_q    <= s_nx;
          cout_q   <= add[SEG];
          zero_q   <= ~|s_nx;
          parity_q <= ~^s_nx;
          ovf_q    <= (a_top == b_top) && (s_nx[WIDTH-1] != a_top);
        end
      end
    end
  end

  assign out_valid = vld_p[STAGES-1];
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed corner sums, streaming with backpressure,
// asynchronous reset mid-flight and randomized traffic against an arithmetic model.
module tb_pipelined_addsub;

  localparam int W = 16;
  localparam int S = 4;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic         c;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] ip1 = '0;
  logic [W-1:0] ip2 = '0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout, zero, parity, overflow;

  int n_chk  = 0;
  int n_pass = 0;

  pipelined_addsub #(.WIDTH(W), .SEG(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ip1(ip1), .ip2(ip2), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .zero(zero), .parity(parity), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #400us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] pk(input logic co, input logic z, input logic p,
                                     input logic ov, input logic [W-1:0] s);
    logic [63:0] r;
    r = '0;
    r[W-1:0]   = s;
    r[W+3:W]   = {co, z, p, ov};
    return r;
  endfunction

  function automatic logic [63:0] outs();
    return pk(cout, zero, parity, overflow, sum);
  endfunction

  // Reference: integer arithmetic on the mathematical values of the operands.
  function automatic logic [63:0] model(input beat_t x);
    longint m, ua, ub, sa, sb, full, sr;
    logic co, ov;
    logic [W-1:0] r;
    m  = longint'(1) << W;
    ua = longint'(x.a);
    ub = longint'(x.b);
    sa = x.a[W-1] ? ua - m : ua;
    sb = x.b[W-1] ? ub - m : ub;
    if (x.s) begin
      full = ua - ub;
      co   = (ua >= ub);
      sr   = sa - sb;
    end else begin
      full = ua + ub + longint'(x.c);
      co   = (full >= m);
      sr   = sa + sb + longint'(x.c);
    end
    ov = (sr > (m / 2) - 1) || (sr < -(m / 2));
    r  = W'(full & (m - 1));
    return pk(co, (r == '0), (($countones(r) % 2) == 0), ov, r);
  endfunction

  function automatic logic [W-1:0] corner_or_rand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      4:       return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  function automatic beat_t gen();
    beat_t x;
    x.a = corner_or_rand();
    x.b = corner_or_rand();
    x.s = 1'($urandom_range(0, 1));
    x.c = 1'($urandom_range(0, 1));
    return x;
  endfunction

  // One isolated beat through an empty pipe, checking latency and the result.
  task automatic one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic s, input logic c, input logic [63:0] exp);
    ip1 = a; ip2 = b; sub = s; cin = c;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check({tag, "_lat3"}, out_valid, 1'b0);
    @(posedge clk); #1;
    check({tag, "_lat4"}, out_valid, 1'b1);
    check(tag, outs(), exp);
    @(posedge clk); #1;
  endtask

  // mode 0: back-to-back, out_ready high; 1: 3-cycle stall mid-stream; 2: random traffic.
  task automatic run(input string tag, input int nbeats, input int mode);
    beat_t       pend[$];
    logic [63:0] expq[$];
    logic [63:0] snap;
    logic        acc, xfer, hold;
    int          cyc, first, last, nx;
    cyc = 0; first = -1; last = -1; nx = 0;
    for (int i = 0; i < nbeats; i++) pend.push_back(gen());
    while ((pend.size() > 0 || expq.size() > 0) && cyc < 4000) begin
      in_valid = (pend.size() > 0) && (mode != 2 || $urandom_range(0, 3) != 0);
      if (pend.size() > 0) begin
        ip1 = pend[0].a; ip2 = pend[0].b; sub = pend[0].s; cin = pend[0].c;
      end
      if (mode == 0)      out_ready = 1'b1;
      else if (mode == 1) out_ready = !(cyc >= 6 && cyc < 9);
      else                out_ready = ($urandom_range(0, 2) != 0);
      #1;
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      hold = out_valid && !out_ready;
      snap = outs();
      if (hold) check({tag, "_stall_in_ready"}, in_ready, 1'b0);
      @(posedge clk); #1;
      if (acc) begin
        expq.push_back(model(pend[0]));
        void'(pend.pop_front());
      end
      if (xfer) begin
        if (expq.size() == 0) begin
          check({tag, "_extra_beat"}, 1'b1, 1'b0);
        end else begin
          check($sformatf("%s_beat%0d", tag, nx), snap, expq.pop_front());
          if (first < 0) first = cyc;
          last = cyc;
          nx++;
        end
      end
      if (hold) begin
        check({tag, "_hold_valid"}, out_valid, 1'b1);
        check({tag, "_hold_data"}, outs(), snap);
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (cyc >= 4000) check({tag, "_timeout"}, 1'b0, 1'b1);
    check({tag, "_beats_out"}, nx, nbeats);
    if (mode == 0) check({tag, "_consecutive"}, last - first, nbeats - 1);
  endtask

  initial begin
    logic stale;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_outputs", outs(), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", in_ready, 1'b1);

    one("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b1, 16'h8000));
    one("wrap0",    16'hFFFF, 16'h0001, 1'b0, 1'b0, pk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000));
    one("sub_brw",  16'h0005, 16'h0007, 1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFE));
    one("sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b1, pk(1'b1, 1'b0, 1'b0, 1'b1, 16'h7FFF));
    one("add_cin",  16'h00FF, 16'h0000, 1'b0, 1'b1, pk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0100));

    run("stream", 6, 0);
    run("stall", 8, 1);
    run("rand", 300, 2);

    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ip1 = W'($urandom); ip2 = W'($urandom); sub = 1'b0; cin = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_outputs", outs(), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stale = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      stale = stale | out_valid;
    end
    check("no_stale", stale, 1'b0);
    one("fresh", 16'h1234, 16'h1111, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b1, 1'b0, 16'h2345));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined adder/subtractor with status flags, the successor to the team's fixed 16-bit four-nibble ripple adder. The carry chain is cut into SEG-bit slices, one slice per pipeline stage, so WIDTH scales without lengthening the critical path. Add and subtract are selectable per operation. Each result carries cout, zero, parity and signed-overflow flags. It sits between an operand-issuing controller and a result consumer, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of SEG.
- SEG, 4, bits per slice/stage, at least 1; STAGES = WIDTH/SEG.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- ip1, ip2  in  WIDTH  operands.
- sub  in  1  0 = ip1+ip2+cin, 1 = ip1-ip2 (cin ignored).
- cin  in  1  carry-in for add mode.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout, zero, parity, overflow  out  1 each  status flags for sum.

## Operation
- Beat accepted on a rising clk edge when in_valid && in_ready.
- Effective operand: b = sub ? ~ip2 : ip2. Effective carry-in: c0 = sub ? 1 : cin.
- Stage k (k = 0..STAGES-1) adds slice k of ip1 and b plus the registered carry from stage k-1 (stage 0 uses c0).
  - Stage k registers its SEG-bit partial sum and its carry-out.
  - Not-yet-used operand slices and already-computed sum slices are delayed alongside, so each beat stays aligned.
- Flags, computed on the full WIDTH sum and registered with it:
  - cout = carry out of the MSB. In sub mode, cout=1 means no borrow.
  - zero = ~|sum.
  - parity = ~^sum, i.e. 1 when sum has an even number of ones.
  - overflow = (ip1[MSB] == b[MSB]) && (sum[MSB] != ip1[MSB]).
- Arithmetic is modulo 2^WIDTH. No saturation.
- Stall is global:
  - en = !out_valid || out_ready.
  - When en = 0, every stage register, every stage valid bit, and all outputs hold.
  - in_ready = en while rst_n is high; in_ready = 0 while rst_n is low.
- Bubbles are not compressed. A stage valid bit travels with its data.
- Beats leave in acceptance order. None are dropped or duplicated.

## Timing
- Reset (rst_n low), asynchronous:
  - all stage valid bits = 0 and out_valid = 0;
  - sum = 0, cout = 0, zero = 0, parity = 0, overflow = 0;
  - in_ready = 0.
- Reset has immediate effect regardless of clk. In-flight beats are discarded and never emitted after release.
- First edge after release: in_ready = 1; acceptance is possible.
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t+STAGES-1, provided no stall occurs (4 edges total with defaults).
- Throughput: one beat per cycle while out_ready stays high.
- Output hold: while out_valid && !out_ready, sum and all flags stay stable and in_ready = 0.
- Release: when out_ready rises, the held result transfers on that edge and the pipeline advances on the same edge.
- Simultaneous output transfer and input acceptance in one cycle is legal and required for full rate.
- Data-path registers carry no reset requirement; valid bits and outputs must reset.
- Elaboration must fail if WIDTH % SEG != 0.

## Test plan
- Add overflow: WIDTH=16, SEG=4, sub=0, cin=0, 0x7FFF + 0x0001 -> sum=0x8000, overflow=1, cout=0, zero=0, parity=0, out_valid after the 4th edge.
- Wrap to zero: 0xFFFF + 0x0001 -> sum=0x0000, cout=1, zero=1, parity=1, overflow=0.
- Subtract with borrow: sub=1, 0x0005 - 0x0007 -> sum=0xFFFE, cout=0, overflow=0, parity=0. Then 0x8000 - 0x0001 -> sum=0x7FFF, overflow=1, cout=1.
- Streaming plus backpressure:
  - Feed 6 back-to-back beats with out_ready=1 -> results on 6 consecutive cycles, in order.
  - Drop out_ready for 3 cycles mid-stream -> output held stable and in_ready=0 during the stall; no beat lost or duplicated.
- Reset mid-operation: accept 3 beats, pull rst_n low asynchronously between edges -> out_valid and in_ready go to 0 immediately; after release, no stale result appears and a fresh 0x1234 + 0x1111 returns 0x2345.
- Parameter sweep: WIDTH=32, SEG=8 and WIDTH=8, SEG=1 against a reference model on random operands, both modes, with random out_ready -> every result and flag matches.
